// File: rtl/rf_wport_arbiter_if.sv
// Writeback-to-regfile bundle: per-source write offers in, the registered
// regfile write port and the contention counter out.
interface rf_wport_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CNTW = 16
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [SW-1:0]        rf_wsrc;
  logic [CNTW-1:0]      contend_cnt;

  // writeback units / environment side
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_wen, rf_waddr, rf_wdata, rf_wsrc, contend_cnt
  );

  // arbiter side
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_wen, rf_waddr, rf_wdata, rf_wsrc, contend_cnt
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among NREQ
// writeback sources, with a one-deep registered output stage.
module rf_wport_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CNTW = 16
) (
  input logic clk,
  input logic rst,
  rf_wport_arbiter_if.slave wp
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [AW-1:0]   addr_arr [NREQ];
  logic [XLEN-1:0] data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = wp.req_addr[gi*AW +: AW];
      assign data_arr[gi] = wp.req_data[gi*XLEN +: XLEN];
    end
  endgenerate

  logic [SW-1:0]   ptr_reg;
  logic [SW-1:0]   ptr_next;
  logic            wen_reg;
  logic [AW-1:0]   waddr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [SW-1:0]   wsrc_reg;
  logic [CNTW-1:0] cnt_reg;

  logic            found;
  logic [SW-1:0]   gnt_idx;
  logic [SW:0]     scan_sum;
  logic [SW-1:0]   scan_idx;
  logic [NREQ-1:0] grant;
  logic            contend;

  // Scan sources starting at ptr, wrapping modulo NREQ; first valid one wins.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_reg} + (SW+1)'(k);
      if (scan_sum >= (SW+1)'(NREQ)) begin
        scan_sum = scan_sum - (SW+1)'(NREQ);
      end
      scan_idx = scan_sum[SW-1:0];
      if (!found && wp.req_valid[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (rst) begin
      found = 1'b0;
    end
  end

  always_comb begin
    grant = '0;
    if (found) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign ptr_next = (gnt_idx == SW'(NREQ - 1)) ? '0 : gnt_idx + SW'(1);
  assign contend  = ($countones(wp.req_valid) >= 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= '0;
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      wsrc_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      if (found) begin
        ptr_reg   <= ptr_next;
        wen_reg   <= (addr_arr[gnt_idx] != '0);
        waddr_reg <= addr_arr[gnt_idx];
        wdata_reg <= data_arr[gnt_idx];
        wsrc_reg  <= gnt_idx;
      end else begin
        wen_reg   <= 1'b0;
      end
      if (contend && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNTW'(1);
      end
    end
  end

  assign wp.req_ready   = grant;
  // A write registered just before reset must never reach the regfile.
  assign wp.rf_wen      = wen_reg & ~rst;
  assign wp.rf_waddr    = waddr_reg;
  assign wp.rf_wdata    = wdata_reg;
  assign wp.rf_wsrc     = wsrc_reg;
  assign wp.contend_cnt = cnt_reg;
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed and random checks of rf_wport_arbiter against a behavioural
// round-robin model that tracks pointer, output stage and contention count.
module tb_rf_wport_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_wport_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW), .CNTW(CNTW)) bus ();

  rf_wport_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .wp  (bus.slave)
  );

  logic            v [NREQ];
  logic [AW-1:0]   a [NREQ];
  logic [XLEN-1:0] d [NREQ];

  int              m_ptr;
  int              m_cnt;
  bit              m_wen;
  logic [AW-1:0]   m_waddr;
  logic [XLEN-1:0] m_wdata;
  int              m_wsrc;
  int              last_gnt;
  int              checks = 0;
  int              passes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]             = v[i];
      bus.req_addr[i*AW +: AW]     = a[i];
      bus.req_data[i*XLEN +: XLEN] = d[i];
    end
  endtask

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: check everything mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int g;
    int nv;
    logic [NREQ-1:0] exp_ready;
    apply();
    @(negedge clk);
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready",   64'(bus.req_ready),   64'(exp_ready));
    chk("rf_wen",      64'(bus.rf_wen),      64'(m_wen && !rst));
    chk("rf_waddr",    64'(bus.rf_waddr),    64'(m_waddr));
    chk("rf_wdata",    64'(bus.rf_wdata),    64'(m_wdata));
    chk("rf_wsrc",     64'(bus.rf_wsrc),     64'(m_wsrc));
    chk("contend_cnt", 64'(bus.contend_cnt), 64'(m_cnt));
    @(posedge clk);
    nv = 0;
    for (int i = 0; i < NREQ; i++) nv += int'(v[i]);
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_wsrc = 0;
    end else begin
      if (g >= 0) begin
        m_ptr   = (g + 1) % NREQ;
        m_wen   = (a[g] != 0);
        m_waddr = a[g];
        m_wdata = d[g];
        m_wsrc  = g;
      end else begin
        m_wen = 0;
      end
      if (nv >= 2 && m_cnt < CMAX) m_cnt++;
    end
    last_gnt = g;
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    m_ptr = 0; m_cnt = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_wsrc = 0;
    last_gnt = -1;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b1;
      a[i] = AW'(i + 3);
      d[i] = XLEN'($urandom);
    end

    // T1: reset with every source requesting
    rst = 1'b1;
    cycle();
    cycle();

    // T2: single write from source 1
    rst = 1'b0;
    clear_all();
    v[1] = 1'b1; a[1] = AW'(5); d[1] = 32'hDEADBEEF;
    cycle();
    v[1] = 1'b0;
    chk("t2_wdata", 64'(bus.rf_wdata), 64'(32'hDEADBEEF));
    chk("t2_wsrc",  64'(bus.rf_wsrc),  64'd1);
    cycle();

    // T3: all three contend for 6 cycles from ptr=0
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        v[i] = 1'b1;
        if (last_gnt == i || c == 0) begin
          a[i] = AW'($urandom_range(1, 31));
          d[i] = XLEN'($urandom);
        end
      end
      cycle();
      chk("t3_order", 64'(last_gnt), 64'(c % NREQ));
    end
    chk("t3_cnt", 64'(bus.contend_cnt), 64'd6);

    // T4: x0 write from source 2 is accepted but never enables the regfile
    clear_all();
    v[2] = 1'b1; a[2] = '0; d[2] = 32'h1234;
    cycle();
    clear_all();
    chk("t4_wen", 64'(bus.rf_wen), 64'd0);
    cycle();
    for (int i = 0; i < NREQ; i++) v[i] = 1'b1;
    cycle();
    chk("t4_ptr_wrap", 64'(last_gnt), 64'd0);

    // T5: counter saturation
    do_reset();
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NREQ; i++) v[i] = 1'b1;
      cycle();
    end
    chk("t5_sat", 64'(bus.contend_cnt), 64'(CMAX));

    // T6: reset right after an acceptance drops the write
    do_reset();
    clear_all();
    v[0] = 1'b1; a[0] = AW'(7); d[0] = 32'hCAFEF00D;
    cycle();
    clear_all();
    rst = 1'b1;
    cycle();
    chk("t6_wen", 64'(bus.rf_wen), 64'd0);
    rst = 1'b0;
    cycle();
    for (int i = 0; i < NREQ; i++) v[i] = 1'b1;
    cycle();
    chk("t6_ptr", 64'(last_gnt), 64'd0);

    // Random phase: sources hold until accepted, occasional resets
    clear_all();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(v[i] && last_gnt != i)) begin
          v[i] = ($urandom_range(0, 2) != 0);
          a[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
          d[i] = XLEN'($urandom);
        end
      end
      cycle();
    end
    rst = 1'b0;
    clear_all();
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
